lp805x_aes_seq: RTL

//  SFR-side sequencer for the AES-128 core. Byte-streams the 16-byte key and

---
 rtl/lp805x_aes_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lp805x_aes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lp805x_aes_seq
//  Description : SFR-side sequencer for the AES-128 core. Byte-streams key and
//                data from the 8051 SFR bus, pulses a one-cycle load to the
//                core, captures the result on ready and streams it back out.
//                Optional interrupt output: define LP805X_AES_IRQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module lp805x_aes_seq #(
    parameter logic [7:0]  SFR_BASE = 8'h00,
    parameter logic [7:0]  RST_CON  = 8'h00,
    parameter logic [15:0] TIMEOUT  = 16'd1023
) (
    input  logic         clk,
    input  logic         rsti,
    input  logic [7:0]   wr_addr,
    input  logic [7:0]   rd_addr,
    input  logic [7:0]   data_in,
    input  logic         wr,
    input  logic         rd,
    input  logic         wr_bit,
    input  logic         rd_bit,
    output logic [7:0]   data_out,
    output logic         bit_out,
    output logic         aes_load,
    output logic         aes_dec,
    output logic [127:0] aes_key,
    output logic [127:0] aes_data,
    input  logic         aes_ready,
    input  logic [127:0] aes_out,
    output logic         irq
);

    localparam logic [7:0] C_ADDR_CON  = SFR_BASE;
    localparam logic [7:0] C_ADDR_DIN  = SFR_BASE + 8'd1;
    localparam logic [7:0] C_ADDR_DOUT = SFR_BASE + 8'd2;
    localparam logic [7:0] C_ADDR_KEY  = SFR_BASE + 8'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic           en_q, en_d, dec_q, dec_d, done_q, done_d, err_q, err_d;
    logic [3:0]     din_ptr_q, din_ptr_d, key_ptr_q, key_ptr_d, out_ptr_q, out_ptr_d;
    logic [127:0]   key_q, key_d, data_q, data_d, result_q, result_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           w_ie, w_busy, w_con_wr, w_din_wr, w_key_wr, w_rd_hit;
    logic           w_start, w_en_now, w_capture, w_set_done, w_set_err;
    logic [7:0]     w_rd_byte;

    assign w_con_wr = wr && !wr_bit && (wr_addr == C_ADDR_CON);
    assign w_din_wr = wr && !wr_bit && (wr_addr == C_ADDR_DIN);
    assign w_key_wr = wr && !wr_bit && (wr_addr == C_ADDR_KEY);
    assign w_rd_hit = rd && !rd_bit && ((rd_addr == C_ADDR_CON) || (rd_addr == C_ADDR_DIN)
                                     || (rd_addr == C_ADDR_DOUT) || (rd_addr == C_ADDR_KEY));
    assign w_busy   = (state_q == S_LOAD) || (state_q == S_RUN);
    assign w_start  = w_con_wr && data_in[5];
    // EN as it will be after this cycle, so a clearing write aborts immediately
    assign w_en_now = w_con_wr ? data_in[7] : en_q;

    // Sequencer next state: load pulse, wait for ready or timeout, flag done
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        w_capture  = 1'b0;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    w_set_done = 1'b1;
                end
                if (w_start && data_in[7]) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                timer_d = 16'd0;
                state_d = w_en_now ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!w_en_now) begin
                    state_d = S_IDLE;
                end else if (aes_ready) begin
                    w_capture = 1'b1;
                    state_d   = S_DONE;
                end else if (timer_q == TIMEOUT - 16'd1) begin
                    w_set_err = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and run timer
    always_ff @(posedge clk or posedge rsti) begin
        if (rsti) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Register-file next state; flag sets by the sequencer override clears by software
    always_comb begin
        en_d      = en_q;
        dec_d     = dec_q;
        done_d    = done_q;
        err_d     = err_q;
        din_ptr_d = din_ptr_q;
        key_ptr_d = key_ptr_q;
        out_ptr_d = out_ptr_q;
        key_d     = key_q;
        data_d    = data_q;
        result_d  = result_q;
        if (w_con_wr) begin
            en_d   = data_in[7];
            dec_d  = data_in[6];
            done_d = done_q & data_in[4];
            err_d  = err_q & data_in[1];
            if (w_start && w_busy) begin
                err_d = 1'b1;
            end
        end
        if (w_din_wr) begin
            if (w_busy) begin
                err_d = 1'b1;
            end else begin
                data_d[{din_ptr_q, 3'b000} +: 8] = data_in;
                din_ptr_d = din_ptr_q + 4'd1;
            end
        end
        if (w_key_wr) begin
            if (w_busy) begin
                err_d = 1'b1;
            end else begin
                key_d[{key_ptr_q, 3'b000} +: 8] = data_in;
                key_ptr_d = key_ptr_q + 4'd1;
            end
        end
        if (w_rd_hit && (rd_addr == C_ADDR_DOUT)) begin
            out_ptr_d = out_ptr_q + 4'd1;
        end
        if (w_con_wr && data_in[0]) begin
            din_ptr_d = 4'd0;
            key_ptr_d = 4'd0;
            out_ptr_d = 4'd0;
        end
        if (w_capture) begin
            result_d  = aes_out;
            out_ptr_d = 4'd0;
        end
        if (w_set_done) begin
            done_d = 1'b1;
        end
        if (w_set_err) begin
            err_d = 1'b1;
        end
    end

    // Read mux: byte at the addressed register's current pointer
    always_comb begin
        w_rd_byte = {en_q, dec_q, 1'b0, done_q, w_busy, w_ie, err_q, 1'b0};
        if (rd_addr == C_ADDR_DIN) begin
            w_rd_byte = data_q[{din_ptr_q, 3'b000} +: 8];
        end else if (rd_addr == C_ADDR_KEY) begin
            w_rd_byte = key_q[{key_ptr_q, 3'b000} +: 8];
        end else if (rd_addr == C_ADDR_DOUT) begin
            w_rd_byte = result_q[{out_ptr_q, 3'b000} +: 8];
        end
        rd_valid_d = w_rd_hit;
        rd_data_d  = w_rd_hit ? w_rd_byte : rd_data_q;
    end

    // Register file, pointers and registered read port
    always_ff @(posedge clk or posedge rsti) begin
        if (rsti) begin
            en_q       <= RST_CON[7];
            dec_q      <= RST_CON[6];
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            din_ptr_q  <= 4'd0;
            key_ptr_q  <= 4'd0;
            out_ptr_q  <= 4'd0;
            key_q      <= 128'd0;
            data_q     <= 128'd0;
            result_q   <= 128'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            en_q       <= en_d;
            dec_q      <= dec_d;
            done_q     <= done_d;
            err_q      <= err_d;
            din_ptr_q  <= din_ptr_d;
            key_ptr_q  <= key_ptr_d;
            out_ptr_q  <= out_ptr_d;
            key_q      <= key_d;
            data_q     <= data_d;
            result_q   <= result_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef LP805X_AES_IRQ_EN
    logic ie_q, ie_d, irq_q;
    assign ie_d = w_con_wr ? data_in[2] : ie_q;
    assign w_ie = ie_q;
    assign irq  = irq_q;

    // Interrupt enable and registered interrupt following the flag next-state
    always_ff @(posedge clk or posedge rsti) begin
        if (rsti) begin
            ie_q  <= RST_CON[2];
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= ie_d & (done_d | err_d);
        end
    end
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    assign aes_load = (state_q == S_LOAD);
    assign aes_dec  = dec_q;
    assign aes_key  = key_q;
    assign aes_data = data_q;
    assign data_out = rd_valid_q ? rd_data_q : 8'hzz;
    assign bit_out  = 1'bz;

endmodule
`default_nettype wire
